otter_mcu_pipeline: RTL and testbench

// Top level of the OTTER RV32I core as a 5-stage in-order pipeline (IF, ID, EX, MEM, WB).

---
 rtl/otter_mcu_pipeline.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_otter_mcu_pipeline.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/otter_mcu_pipeline.sv
// OTTER RV32I core: 5-stage in-order pipeline (IF, ID, EX, MEM, WB) with forwarding,
// load-use stall, predict-not-taken branches, unified byte-enabled memory and IOBUS.
module otter_mcu_pipeline #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] IO_BASE   = 32'h1100_0000,
    parameter logic [31:0] NOP       = 32'h0000_0013,
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        INTR,
    input  logic [31:0] IOBUS_IN,
    output logic [31:0] IOBUS_OUT,
    output logic [31:0] IOBUS_ADDR,
    output logic        IOBUS_WR
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic       regwr, memwr, memrd, branch, jal, jalr, link, a_pc, a_zero, b_imm;
        logic [3:0] alu_fun;
        logic [2:0] f3;
    } ctrl_t;

    logic [31:0] mem [0:MEM_WORDS-1];
    logic [31:0] rf  [0:31];

    logic        unused_intr;
    assign unused_intr = INTR;

    // IF and IF/ID
    logic [31:0] pc, if_id_ir, if_id_pc;

    // ID
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic [31:0] id_imm, id_rs1v, id_rs2v;
    ctrl_t       id_c;
    logic        load_use;

    // ID/EX
    ctrl_t       id_ex_c;
    logic [31:0] id_ex_pc, id_ex_rs1v, id_ex_rs2v, id_ex_imm;
    logic [4:0]  id_ex_rd, id_ex_rs1, id_ex_rs2;

    // EX
    logic [31:0] fwd1, fwd2, alu_a, alu_b, alu_y, ex_target, ex_res, dm_rword, be_mask;
    logic        br_cond, ex_taken;

    // EX/MEM
    logic        ex_mem_regwr, ex_mem_memwr, ex_mem_memrd;
    logic [2:0]  ex_mem_f3;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_alu, ex_mem_rs2, ex_mem_res, ex_mem_rdata;

    // MEM
    logic        mem_io, dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;

    // MEM/WB and WB
    logic        mem_wb_regwr, mem_wb_memrd, wb_we;
    logic [2:0]  mem_wb_f3;
    logic [1:0]  mem_wb_lo;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_res, mem_wb_ld, ld_shift, ld_ext, wb_val;

    // ---------------- ID: decode, immediates, register read ----------------
    assign id_rd  = if_id_ir[11:7];
    assign id_rs1 = if_id_ir[19:15];
    assign id_rs2 = if_id_ir[24:20];

    always_comb begin
        id_c    = '0;
        id_c.f3 = if_id_ir[14:12];
        id_imm  = {{20{if_id_ir[31]}}, if_id_ir[31:20]};
        case (if_id_ir[6:0])
            OP_LUI: begin
                id_c.regwr = 1'b1; id_c.a_zero = 1'b1; id_c.b_imm = 1'b1;
                id_imm = {if_id_ir[31:12], 12'b0};
            end
            OP_AUIPC: begin
                id_c.regwr = 1'b1; id_c.a_pc = 1'b1; id_c.b_imm = 1'b1;
                id_imm = {if_id_ir[31:12], 12'b0};
            end
            OP_JAL: begin
                id_c.regwr = 1'b1; id_c.link = 1'b1; id_c.jal = 1'b1;
                id_imm = {{11{if_id_ir[31]}}, if_id_ir[31], if_id_ir[19:12],
                          if_id_ir[20], if_id_ir[30:21], 1'b0};
            end
            OP_JALR: begin
                id_c.regwr = 1'b1; id_c.link = 1'b1; id_c.jalr = 1'b1;
            end
            OP_BRANCH: begin
                id_c.branch = 1'b1;
                id_imm = {{19{if_id_ir[31]}}, if_id_ir[31], if_id_ir[7],
                          if_id_ir[30:25], if_id_ir[11:8], 1'b0};
            end
            OP_LOAD: begin
                id_c.regwr = 1'b1; id_c.memrd = 1'b1; id_c.b_imm = 1'b1;
            end
            OP_STORE: begin
                id_c.memwr = 1'b1; id_c.b_imm = 1'b1;
                id_imm = {{20{if_id_ir[31]}}, if_id_ir[31:25], if_id_ir[11:7]};
            end
            OP_IMM: begin
                // bit 30 is an immediate bit except for the shift-right pair
                id_c.regwr = 1'b1; id_c.b_imm = 1'b1;
                id_c.alu_fun = {(if_id_ir[14:12] == 3'b101) & if_id_ir[30], if_id_ir[14:12]};
            end
            OP_REG: begin
                id_c.regwr = 1'b1;
                id_c.alu_fun = {if_id_ir[30], if_id_ir[14:12]};
            end
            default: id_c = '0;
        endcase
    end

    // WB write is visible to a same-cycle read
    always_comb begin
        id_rs1v = '0;
        id_rs2v = '0;
        if (id_rs1 != 5'd0) id_rs1v = (wb_we && mem_wb_rd == id_rs1) ? wb_val : rf[id_rs1];
        if (id_rs2 != 5'd0) id_rs2v = (wb_we && mem_wb_rd == id_rs2) ? wb_val : rf[id_rs2];
    end

    assign load_use = id_ex_c.memrd && (id_ex_rd != 5'd0) &&
                      ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

    // ---------------- EX: forwarding, ALU, branch resolution ----------------
    always_comb begin
        fwd1 = id_ex_rs1v;
        fwd2 = id_ex_rs2v;
        if (id_ex_rs1 != 5'd0) begin
            if (ex_mem_regwr && ex_mem_rd == id_ex_rs1)  fwd1 = ex_mem_res;
            else if (wb_we && mem_wb_rd == id_ex_rs1)    fwd1 = wb_val;
        end
        if (id_ex_rs2 != 5'd0) begin
            if (ex_mem_regwr && ex_mem_rd == id_ex_rs2)  fwd2 = ex_mem_res;
            else if (wb_we && mem_wb_rd == id_ex_rs2)    fwd2 = wb_val;
        end
    end

    always_comb begin
        alu_a = id_ex_c.a_zero ? '0 : (id_ex_c.a_pc ? id_ex_pc : fwd1);
        alu_b = id_ex_c.b_imm ? id_ex_imm : fwd2;
        alu_y = '0;
        casez (id_ex_c.alu_fun)
            4'b0000: alu_y = alu_a + alu_b;
            4'b1000: alu_y = alu_a - alu_b;
            4'b?001: alu_y = alu_a << alu_b[4:0];
            4'b?010: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'b?011: alu_y = {31'b0, alu_a < alu_b};
            4'b?100: alu_y = alu_a ^ alu_b;
            4'b0101: alu_y = alu_a >> alu_b[4:0];
            4'b1101: alu_y = $signed(alu_a) >>> alu_b[4:0];
            4'b?110: alu_y = alu_a | alu_b;
            4'b?111: alu_y = alu_a & alu_b;
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        case (id_ex_c.f3)
            3'b000:  br_cond = (fwd1 == fwd2);
            3'b001:  br_cond = (fwd1 != fwd2);
            3'b100:  br_cond = ($signed(fwd1) <  $signed(fwd2));
            3'b101:  br_cond = ($signed(fwd1) >= $signed(fwd2));
            3'b110:  br_cond = (fwd1 <  fwd2);
            3'b111:  br_cond = (fwd1 >= fwd2);
            default: br_cond = 1'b0;
        endcase
    end

    assign ex_taken  = (id_ex_c.branch && br_cond) || id_ex_c.jal || id_ex_c.jalr;
    assign ex_target = id_ex_c.jalr ? ((fwd1 + id_ex_imm) & ~32'd1) : (id_ex_pc + id_ex_imm);
    assign ex_res    = id_ex_c.link ? (id_ex_pc + 32'd4) : alu_y;

    // Synchronous data read issued from EX; a store retiring in MEM on the same edge wins
    assign be_mask  = {{8{dm_be[3]}}, {8{dm_be[2]}}, {8{dm_be[1]}}, {8{dm_be[0]}}};
    assign dm_rword = (dm_we && ex_mem_alu[AW+1:2] == alu_y[AW+1:2])
                    ? ((mem[alu_y[AW+1:2]] & ~be_mask) | (dm_wdata & be_mask))
                    : mem[alu_y[AW+1:2]];

    // ---------------- MEM: data memory / IOBUS ----------------
    assign mem_io = (ex_mem_alu >= IO_BASE);
    assign dm_we  = ex_mem_memwr && !mem_io;

    always_comb begin
        case (ex_mem_f3[1:0])
            2'b00: begin
                dm_be    = 4'b0001 << ex_mem_alu[1:0];
                dm_wdata = {4{ex_mem_rs2[7:0]}};
            end
            2'b01: begin
                dm_be    = 4'b0011 << {ex_mem_alu[1], 1'b0};
                dm_wdata = {2{ex_mem_rs2[15:0]}};
            end
            default: begin
                dm_be    = 4'b1111;
                dm_wdata = ex_mem_rs2;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (dm_we) begin
            if (dm_be[0]) mem[ex_mem_alu[AW+1:2]][7:0]   <= dm_wdata[7:0];
            if (dm_be[1]) mem[ex_mem_alu[AW+1:2]][15:8]  <= dm_wdata[15:8];
            if (dm_be[2]) mem[ex_mem_alu[AW+1:2]][23:16] <= dm_wdata[23:16];
            if (dm_be[3]) mem[ex_mem_alu[AW+1:2]][31:24] <= dm_wdata[31:24];
        end
    end

    assign IOBUS_ADDR = ex_mem_alu;
    assign IOBUS_OUT  = ex_mem_rs2;
    assign IOBUS_WR   = ex_mem_memwr && mem_io;

    // ---------------- WB ----------------
    assign ld_shift = mem_wb_ld >> {mem_wb_lo, 3'b000};

    always_comb begin
        case (mem_wb_f3)
            3'b000:  ld_ext = {{24{ld_shift[7]}},  ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'b0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'b0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    assign wb_val = mem_wb_memrd ? ld_ext : mem_wb_res;
    assign wb_we  = mem_wb_regwr && (mem_wb_rd != 5'd0);

    always_ff @(posedge CLK) begin
        if (wb_we) rf[mem_wb_rd] <= wb_val;
    end

    // ---------------- PC and pipeline registers ----------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc <= RESET_VEC;
            if_id_ir <= NOP;  if_id_pc <= '0;
            id_ex_c <= '0;    id_ex_pc <= '0;  id_ex_rs1v <= '0; id_ex_rs2v <= '0;
            id_ex_imm <= '0;  id_ex_rd <= '0;  id_ex_rs1 <= '0;  id_ex_rs2 <= '0;
            ex_mem_regwr <= 1'b0; ex_mem_memwr <= 1'b0; ex_mem_memrd <= 1'b0;
            ex_mem_f3 <= '0;  ex_mem_rd <= '0; ex_mem_alu <= '0; ex_mem_rs2 <= '0;
            ex_mem_res <= '0; ex_mem_rdata <= '0;
            mem_wb_regwr <= 1'b0; mem_wb_memrd <= 1'b0; mem_wb_f3 <= '0;
            mem_wb_lo <= '0;  mem_wb_rd <= '0; mem_wb_res <= '0; mem_wb_ld <= '0;
        end else begin
            // a taken branch/jump flushes IF/ID and ID/EX and overrides any stall
            if (ex_taken) begin
                pc       <= ex_target;
                if_id_ir <= NOP;
            end else if (!load_use) begin
                pc       <= pc + 32'd4;
                if_id_ir <= mem[pc[AW+1:2]];
                if_id_pc <= pc;
            end

            if (ex_taken || load_use) begin
                id_ex_c  <= '0;
                id_ex_rd <= '0; id_ex_rs1 <= '0; id_ex_rs2 <= '0;
            end else begin
                id_ex_c  <= id_c;
                id_ex_rd <= id_rd; id_ex_rs1 <= id_rs1; id_ex_rs2 <= id_rs2;
            end
            id_ex_pc   <= if_id_pc;
            id_ex_rs1v <= id_rs1v;
            id_ex_rs2v <= id_rs2v;
            id_ex_imm  <= id_imm;

            ex_mem_regwr <= id_ex_c.regwr;
            ex_mem_memwr <= id_ex_c.memwr;
            ex_mem_memrd <= id_ex_c.memrd;
            ex_mem_f3    <= id_ex_c.f3;
            ex_mem_rd    <= id_ex_rd;
            ex_mem_alu   <= alu_y;
            ex_mem_rs2   <= fwd2;
            ex_mem_res   <= ex_res;
            ex_mem_rdata <= dm_rword;

            mem_wb_regwr <= ex_mem_regwr;
            mem_wb_memrd <= ex_mem_memrd;
            mem_wb_f3    <= ex_mem_f3;
            mem_wb_lo    <= ex_mem_alu[1:0];
            mem_wb_rd    <= ex_mem_rd;
            mem_wb_res   <= ex_mem_res;
            mem_wb_ld    <= mem_io ? IOBUS_IN : ex_mem_rdata;
        end
    end
endmodule

// File: tb/tb_otter_mcu_pipeline.sv
// Directed bench for otter_mcu_pipeline: a program reports its results through IOBUS stores,
// which are scoreboarded against values the bench works out for itself.
module tb_otter_mcu_pipeline;
    localparam logic [31:0] IO = 32'h1100_0000;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_JAL = 7'b1101111, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_LD  = 7'b0000011, OP_IMM = 7'b0010011;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        INTR = 1'b0;
    logic [31:0] IOBUS_IN = 32'h0000_CAFE;
    logic [31:0] IOBUS_OUT, IOBUS_ADDR;
    logic        IOBUS_WR;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] prog[$];
    logic [63:0] exp_q[$];

    otter_mcu_pipeline #(.RESET_VEC(32'h0), .IO_BASE(IO), .NOP(32'h0000_0013)) dut (
        .CLK(CLK), .RESET(RESET), .INTR(INTR), .IOBUS_IN(IOBUS_IN),
        .IOBUS_OUT(IOBUS_OUT), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_WR(IOBUS_WR)
    );

    always #10 CLK = ~CLK;

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BR};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic build_program();
        prog.delete();
        prog.push_back({20'h11000, 5'd6, OP_LUI});                // 0  lui  x6,0x11000
        prog.push_back(enc_i(OP_IMM, 5, 3'b000, 0, 12'd0));       // 1  addi x5,x0,0
        prog.push_back(enc_i(OP_IMM, 1, 3'b000, 0, 12'd5));       // 2  addi x1,x0,5
        prog.push_back(enc_i(OP_IMM, 2, 3'b000, 1, 12'd3));       // 3  addi x2,x1,3
        prog.push_back(enc_i(OP_LD, 3, 3'b010, 0, 12'h100));      // 4  lw   x3,0x100(x0)
        prog.push_back(enc_r(7'd0, 3, 3, 3'b000, 4));             // 5  add  x4,x3,x3
        prog.push_back(enc_b(3'b000, 0, 0, 13'd12));              // 6  beq  x0,x0,+12
        prog.push_back(enc_i(OP_IMM, 5, 3'b000, 0, 12'd1));       // 7  addi x5,x0,1
        prog.push_back(enc_i(OP_IMM, 5, 3'b000, 0, 12'd1));       // 8  addi x5,x0,1
        prog.push_back(enc_i(OP_IMM, 7, 3'b000, 0, 12'h0AA));     // 9  addi x7,x0,0xAA
        prog.push_back(enc_s(3'b010, 6, 7, 12'd0));               // 10 sw x7,0(x6)
        prog.push_back(enc_s(3'b010, 6, 2, 12'd4));               // 11 sw x2,4(x6)
        prog.push_back(enc_s(3'b010, 6, 4, 12'd8));               // 12 sw x4,8(x6)
        prog.push_back(enc_s(3'b010, 6, 5, 12'd12));              // 13 sw x5,12(x6)
        prog.push_back(enc_i(OP_LD, 8, 3'b010, 6, 12'd16));       // 14 lw x8,16(x6)
        prog.push_back(enc_s(3'b010, 6, 8, 12'd20));              // 15 sw x8,20(x6)
        prog.push_back(enc_i(OP_IMM, 0, 3'b000, 0, 12'd7));       // 16 addi x0,x0,7
        prog.push_back(enc_s(3'b010, 6, 0, 12'd24));              // 17 sw x0,24(x6)
        prog.push_back(enc_i(OP_IMM, 9, 3'b000, 0, 12'hFFF));     // 18 addi x9,x0,-1
        prog.push_back(enc_i(OP_IMM, 10, 3'b101, 9, 12'd28));     // 19 srli x10,x9,28
        prog.push_back(enc_i(OP_IMM, 11, 3'b101, 9, 12'h404));    // 20 srai x11,x9,4
        prog.push_back(enc_r(7'd0, 9, 0, 3'b011, 12));            // 21 sltu x12,x0,x9
        prog.push_back(enc_r(7'd0, 0, 9, 3'b010, 13));            // 22 slt  x13,x9,x0
        prog.push_back(enc_s(3'b010, 6, 10, 12'd28));             // 23 sw x10,28(x6)
        prog.push_back(enc_s(3'b010, 6, 11, 12'd32));             // 24 sw x11,32(x6)
        prog.push_back(enc_r(7'd0, 13, 12, 3'b000, 14));          // 25 add x14,x12,x13
        prog.push_back(enc_s(3'b010, 6, 14, 12'd36));             // 26 sw x14,36(x6)
        prog.push_back(enc_s(3'b000, 0, 9, 12'h101));             // 27 sb x9,0x101(x0)
        prog.push_back(enc_i(OP_LD, 15, 3'b000, 0, 12'h101));     // 28 lb  x15,0x101(x0)
        prog.push_back(enc_i(OP_LD, 16, 3'b100, 0, 12'h101));     // 29 lbu x16,0x101(x0)
        prog.push_back(enc_s(3'b010, 6, 15, 12'd40));             // 30 sw x15,40(x6)
        prog.push_back(enc_s(3'b010, 6, 16, 12'd44));             // 31 sw x16,44(x6)
        prog.push_back(enc_j(17, 21'd8));                         // 32 jal x17,+8
        prog.push_back(enc_i(OP_IMM, 17, 3'b000, 0, 12'd1));      // 33 addi x17,x0,1
        prog.push_back(enc_s(3'b010, 6, 17, 12'd48));             // 34 sw x17,48(x6)
        prog.push_back(enc_b(3'b001, 0, 0, 13'd8));               // 35 bne x0,x0,+8
        prog.push_back(enc_i(OP_IMM, 18, 3'b000, 0, 12'h033));    // 36 addi x18,x0,0x33
        prog.push_back(enc_s(3'b010, 6, 18, 12'd52));             // 37 sw x18,52(x6)
        prog.push_back(enc_i(OP_LD, 19, 3'b010, 0, 12'h100));     // 38 lw x19,0x100(x0)
        prog.push_back(enc_s(3'b010, 6, 19, 12'd56));             // 39 sw x19,56(x6)
        prog.push_back(enc_j(0, 21'd0));                          // 40 jal x0,0
    endtask

    task automatic push_expected();
        exp_q.delete();
        exp_q.push_back({IO + 32'd0,  32'h0000_00AA});
        exp_q.push_back({IO + 32'd4,  32'h0000_0008});
        exp_q.push_back({IO + 32'd8,  32'h0000_2468});
        exp_q.push_back({IO + 32'd12, 32'h0000_0000});
        exp_q.push_back({IO + 32'd20, 32'h0000_CAFE});
        exp_q.push_back({IO + 32'd24, 32'h0000_0000});
        exp_q.push_back({IO + 32'd28, 32'h0000_000F});
        exp_q.push_back({IO + 32'd32, 32'hFFFF_FFFF});
        exp_q.push_back({IO + 32'd36, 32'h0000_0002});
        exp_q.push_back({IO + 32'd40, 32'hFFFF_FFFF});
        exp_q.push_back({IO + 32'd44, 32'h0000_00FF});
        exp_q.push_back({IO + 32'd48, 32'h0000_0084});
        exp_q.push_back({IO + 32'd52, 32'h0000_0033});
        exp_q.push_back({IO + 32'd56, 32'h0000_FF34});
    endtask

    task automatic run_sb(input int unsigned max_cycles, input bit stop_at_first);
        logic [63:0] e;
        for (int unsigned c = 0; c < max_cycles; c++) begin
            @(negedge CLK);
            if (IOBUS_WR === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", {31'b0, IOBUS_WR}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("io_addr", IOBUS_ADDR, e[63:32]);
                    check("io_data", IOBUS_OUT, e[31:0]);
                    if (stop_at_first) return;
                end
            end
        end
    endtask

    initial begin
        build_program();
        foreach (prog[i]) dut.mem[i] = prog[i];
        dut.mem[64] = 32'h0000_1234;
        push_expected();

        // reset pulse 5..11 ns
        #5 RESET = 1'b1;
        #1;
        check("rst_pc", dut.pc, 32'h0);
        check("rst_wr", {31'b0, IOBUS_WR}, 32'd0);
        check("rst_out", IOBUS_OUT, 32'h0);
        check("rst_addr", IOBUS_ADDR, 32'h0);
        #5 RESET = 1'b0;
        @(posedge CLK);
        #1;
        check("first_fetch_pc", dut.pc, 32'h4);
        check("first_fetch_ir", dut.if_id_ir, prog[0]);

        run_sb(200, 1'b0);
        check("drain_pass1", exp_q.size(), 32'd0);

        // restart, then hit reset asynchronously while the first IO store is in MEM
        @(negedge CLK);
        RESET = 1'b1;
        dut.mem[64] = 32'h0000_1234;
        push_expected();
        #1;
        check("rst2_pc", dut.pc, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        run_sb(200, 1'b1);
        check("pass2_first_store", exp_q.size(), 32'd13);
        RESET = 1'b1;
        #1;
        check("midrst_wr", {31'b0, IOBUS_WR}, 32'd0);
        check("midrst_addr", IOBUS_ADDR, 32'h0);
        check("midrst_out", IOBUS_OUT, 32'h0);
        check("midrst_pc", dut.pc, 32'h0);
        dut.mem[64] = 32'h0000_1234;
        push_expected();
        #4 RESET = 1'b0;

        run_sb(200, 1'b0);
        check("drain_pass3", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
